// File: rtl/c17_key_pkg.sv
// Shared types and default constants for the c17 key-delivery stage.
package c17_key_pkg;
  localparam int              KEY_W     = 4;
  localparam int              TRY_W     = 2;
  localparam int              MAX_TRIES = 3;
  localparam logic [KEY_W-1:0] DECOY_KEY = 4'b1101;

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, LOADED, LOCKOUT} state_e;
endpackage

// File: rtl/key_sipo.sv
// Serial-in key capture: LSB-first data bits, then one parity bit, with a running XOR.
module key_sipo #(
  parameter int KEY_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] data,
  output logic             par_ok,
  output logic             last
);
  localparam int CNT_W = $clog2(KEY_W + 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] data_q, data_d;
  logic             par_q, par_d;

  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    par_d  = par_q;
    if (clr) begin
      cnt_d  = '0;
      data_d = '0;
      par_d  = 1'b0;
    end else if (shift_en) begin
      cnt_d = cnt_q + 1'b1;
      par_d = par_q ^ bit_in;
      // Shifting in from the MSB leaves the first bit in slot 0 after KEY_W shifts;
      // the trailing parity bit only feeds the running XOR.
      if (cnt_q < CNT_W'(KEY_W)) data_d = {bit_in, data_q[KEY_W-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      data_q <= '0;
      par_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      par_q  <= par_d;
    end
  end

  assign data   = data_q;
  assign par_ok = ~par_q;
  assign last   = shift_en & (cnt_q == CNT_W'(KEY_W));
endmodule

// File: rtl/c17_key_loader.sv
// Write-once, parity-checked key loader feeding keyinput[] of the locked c17 core.
// The core sees DECOY_KEY until a verified load completes, and forever after lockout.
module c17_key_loader #(
  parameter int               KEY_W     = c17_key_pkg::KEY_W,
  parameter logic [KEY_W-1:0] DECOY_KEY = c17_key_pkg::DECOY_KEY,
  parameter int               MAX_TRIES = c17_key_pkg::MAX_TRIES,
  parameter int               TRY_W     = c17_key_pkg::TRY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             key_bit,
  input  logic             key_vld,
  output logic             key_rdy,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             lockout,
  output logic [TRY_W-1:0] tries
);
  import c17_key_pkg::*;

  state_e           state_q, state_d;
  logic             key_rdy_q, key_rdy_d;
  logic             key_valid_q, key_valid_d;
  logic             key_err_q, key_err_d;
  logic             lockout_q, lockout_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic [TRY_W-1:0] tries_q, tries_d;

  logic             xfer, sipo_clr, sipo_last, par_ok;
  logic [KEY_W-1:0] sipo_data;

  assign xfer     = (state_q == SHIFT) & key_vld & key_rdy_q;
  assign sipo_clr = ((state_q == IDLE) & start) | ((state_q == CHECK) & ~par_ok);

  key_sipo #(.KEY_W(KEY_W)) u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (sipo_clr),
    .shift_en (xfer),
    .bit_in   (key_bit),
    .data     (sipo_data),
    .par_ok   (par_ok),
    .last     (sipo_last)
  );

  always_comb begin
    state_d     = state_q;
    key_rdy_d   = key_rdy_q;
    key_valid_d = key_valid_q;
    key_err_d   = 1'b0;
    lockout_d   = lockout_q;
    key_out_d   = key_out_q;
    tries_d     = tries_q;
    case (state_q)
      IDLE: if (start) begin
        state_d   = SHIFT;
        key_rdy_d = 1'b1;
      end
      SHIFT: if (sipo_last) begin
        state_d   = CHECK;
        key_rdy_d = 1'b0;
      end
      CHECK: if (par_ok) begin
        state_d     = LOADED;
        key_out_d   = sipo_data;
        key_valid_d = 1'b1;
      end else begin
        key_err_d = 1'b1;
        if (tries_q != TRY_W'(MAX_TRIES)) tries_d = tries_q + 1'b1;
        if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
          state_d   = LOCKOUT;
          lockout_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOADED, LOCKOUT: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_rdy_q   <= 1'b0;
      key_valid_q <= 1'b0;
      key_err_q   <= 1'b0;
      lockout_q   <= 1'b0;
      key_out_q   <= DECOY_KEY;
      tries_q     <= '0;
    end else begin
      state_q     <= state_d;
      key_rdy_q   <= key_rdy_d;
      key_valid_q <= key_valid_d;
      key_err_q   <= key_err_d;
      lockout_q   <= lockout_d;
      key_out_q   <= key_out_d;
      tries_q     <= tries_d;
    end
  end

  assign key_rdy   = key_rdy_q;
  assign key_valid = key_valid_q;
  assign key_err   = key_err_q;
  assign lockout   = lockout_q;
  assign key_out   = key_out_q;
  assign tries     = tries_q;
endmodule

// File: tb/tb_c17_key_loader.sv
// Randomized bench for c17_key_loader: a queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_c17_key_loader;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, key_bit = 1'b0, key_vld = 1'b0;
  logic       key_rdy, key_valid, key_err, lockout;
  logic [3:0] key_out;
  logic [1:0] tries;
  int         n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  c17_key_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_bit(key_bit), .key_vld(key_vld),
    .key_rdy(key_rdy), .key_out(key_out), .key_valid(key_valid), .key_err(key_err),
    .lockout(lockout), .tries(tries)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: bits collected in a queue; outcome decided by whole-word parity.
  int         m_ph;        // 0 waiting, 1 collecting, 2 verdict, 3 loaded, 4 locked
  bit         m_bits[$];
  bit         m_p;
  logic [3:0] m_key;
  logic       m_valid, m_rdy, m_err, m_lock;
  int         m_tries;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_bits.delete(); m_key = 4'b1101;
      m_valid = 0; m_rdy = 0; m_err = 0; m_lock = 0; m_tries = 0;
    end else begin
      m_err = 0;
      case (m_ph)
        0: if (start) begin m_ph = 1; m_rdy = 1; m_bits.delete(); end
        1: if (key_vld) begin
          m_bits.push_back(key_bit);
          if (m_bits.size() == 5) begin m_ph = 2; m_rdy = 0; end
        end
        2: begin
          m_p = 0;
          foreach (m_bits[i]) m_p ^= m_bits[i];
          if (!m_p) begin
            for (int i = 0; i < 4; i++) m_key[i] = m_bits[i];
            m_valid = 1; m_ph = 3;
          end else begin
            m_err = 1;
            if (m_tries < 3) m_tries++;
            if (m_tries == 3) begin m_ph = 4; m_lock = 1; end
            else m_ph = 0;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("key_rdy",   key_rdy,   m_rdy);
      chk("key_out",   key_out,   m_key);
      chk("key_valid", key_valid, m_valid);
      chk("key_err",   key_err,   m_err);
      chk("lockout",   lockout,   m_lock);
      chk("tries",     tries,     m_tries[1:0]);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge right after the parity bit's edge.
  task automatic send(input logic [4:0] b, input int stall_at, input int stall_len,
                      input bit rnd, input bit pin_rdy);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == stall_at) begin
        key_vld = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          if (pin_rdy) chk("stall_rdy", key_rdy, 1'b1);
        end
      end
      if (rnd) begin
        key_vld = 1'b0;
        key_bit = 1'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        start = 1'($urandom);
      end
      key_vld = 1'b1;
      key_bit = b[i];
      @(negedge clk);
    end
    key_vld = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    logic [4:0] rb;
    repeat (2) @(negedge clk);
    chk("rst_key_out", key_out, 4'b1101);
    chk("rst_valid",   key_valid, 1'b0);
    chk("rst_rdy",     key_rdy, 1'b0);
    chk("rst_tries",   tries, 2'd0);
    chk("rst_lockout", lockout, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("decoy_idle", key_out, 4'b1101);

    // Good load 0,1,0,0 + parity 1
    send(5'b1_0010, -1, 0, 0, 0);
    chk("t1_check_cycle_valid", key_valid, 1'b0);
    @(negedge clk);
    chk("t1_valid", key_valid, 1'b1);
    chk("t1_key",   key_out, 4'b0010);

    // Bad parity, then two more -> lockout, then a refused good load
    do_reset();
    send(5'b0_0010, -1, 0, 0, 0);
    chk("t3_err_early", key_err, 1'b0);
    @(negedge clk);
    chk("t3_err",   key_err, 1'b1);
    chk("t3_tries", tries, 2'd1);
    chk("t3_key",   key_out, 4'b1101);
    @(negedge clk);
    chk("t3_err_once", key_err, 1'b0);
    send(5'b0_0111, -1, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("t4_tries2", tries, 2'd2);
    chk("t4_nolock", lockout, 1'b0);
    send(5'b1_0000, -1, 0, 0, 0);
    @(negedge clk);
    chk("t4_lockout", lockout, 1'b1);
    chk("t4_tries3",  tries, 2'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_refused_rdy", key_rdy, 1'b0);
    send(5'b1_0010, -1, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("t4_key_decoy", key_out, 4'b1101);
    chk("t4_no_valid",  key_valid, 1'b0);

    // Stall mid-shift, then an attempted reload after LOADED
    do_reset();
    send(5'b1_1011, 2, 5, 0, 1);
    @(negedge clk);
    chk("t5_key",   key_out, 4'b1011);
    chk("t5_valid", key_valid, 1'b1);
    send(5'b0_0110, -1, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("t5_key_held", key_out, 4'b1011);

    // Reset mid-shift after one failure and two bits
    do_reset();
    send(5'b0_0001, -1, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("t6_tries_pre", tries, 2'd1);
    start = 1'b1; @(negedge clk); start = 1'b0;
    key_vld = 1'b1; key_bit = 1'b1; @(negedge clk);
    key_bit = 1'b0; @(negedge clk);
    key_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_key",   key_out, 4'b1101);
    chk("t6_rst_rdy",   key_rdy, 1'b0);
    chk("t6_rst_tries", tries, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(5'b1_0010, -1, 0, 0, 0);
    @(negedge clk);
    chk("t6_valid", key_valid, 1'b1);
    chk("t6_key",   key_out, 4'b0010);
    chk("t6_tries", tries, 2'd0);

    // Random loads with gaps, start noise and occasional resets
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      rb = 5'($urandom);
      send(rb, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1, 0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
